// File: rtl/serial_alu_driver.sv
// rtl/serial_alu_driver.sv - bit-serial a+b+cin adder with valid/ready operand and result handshakes
// Optional macro SERIAL_ALU_SUB_EN adds a sub input that inverts b at latch time.
module serial_alu_driver #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ALU_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res_q, res_shift, b_eff;
  logic [CW-1:0]    cnt;
  logic             c, cout_q, ov_q;
  logic             sum_bit, carry_nxt, last_bit;

`ifdef SERIAL_ALU_SUB_EN
  assign b_eff = sub ? ~b : b;
`else
  assign b_eff = b;
`endif

  assign sum_bit   = sa[0] ^ sb[0] ^ c;
  assign carry_nxt = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at result[0].
  generate
    if (WIDTH == 1) begin : g_w1
      assign res_shift = sum_bit;
    end else begin : g_wn
      assign res_shift = {sum_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b_eff;
            c     <= cin;
            cnt   <= '0;
            res_q <= '0;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          c     <= carry_nxt;
          cnt   <= cnt + CW'(1);
          res_q <= res_shift;
          if (last_bit) begin
            ov_q   <= 1'b1;
            cout_q <= carry_nxt;
          end
        end
        DONE: begin
          if (out_ready) ov_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = ov_q;
  assign result    = res_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_alu_driver.sv
// tb/tb_serial_alu_driver.sv - randomized self-checking bench for serial_alu_driver against an arithmetic model
module tb_serial_alu_driver;

  localparam int W = 3;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ALU_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_alu_driver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ALU_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Model: {cout,result} = a + (sub ? ~b : b) + cin in W+1 bits.
  function automatic int model_sum(input int av, input int bv, input int cv, input int sv);
    int be;
    be = sv ? (~bv & MASK) : bv;
    return av + be + cv;
  endfunction

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drive_sub(input int sv);
`ifdef SERIAL_ALU_SUB_EN
    sub = sv[0];
`endif
  endtask

  task automatic do_op(input int av, input int bv, input int cv, input int sv, input int hold);
    int n, sum;
    sum = model_sum(av, bv, cv, sv);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = av[W-1:0]; b = bv[W-1:0]; cin = cv[0]; drive_sub(sv);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check("busy_run", busy, 1);
    wait_out(n);
    check("latency", n, W);
    check("result", result, sum & MASK);
    check("cout", cout, (sum >> W) & 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, sum & MASK);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int n, k, t1, t2, seen;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    do_op(3, 2, 0, 0, 0);
    do_op(7, 1, 1, 0, 0);
    do_op(7, 7, 1, 0, 0);
    do_op(0, 0, 0, 0, 0);

    // Backpressure with new operands waiting on in_valid.
    @(negedge clk);
    in_valid = 1'b1; a = 3'd4; b = 3'd1; cin = 1'b0; drive_sub(0); out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 3'd6; b = 3'd3;
    wait_out(n);
    check("bp_latency", n, W);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 5);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept", busy, 1);
    wait_out(n);
    check("bp2_latency", n, W);
    check("bp2_result", result, 1);
    check("bp2_cout", cout, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset one RUN edge into an operation.
    @(negedge clk);
    in_valid = 1'b1; a = 3'd5; b = 3'd2; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_result", result, 0);
    check("ar_cout", cout, 0);
    check("ar_busy", busy, 0);
    check("ar_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("ar_no_output", seen, 0);
    do_op(1, 1, 0, 0, 0);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; a = 3'd0; b = 3'd0; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 3'd6; b = 3'd1;
    t1 = -1; t2 = -1;
    for (k = 1; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        if (t1 < 0) begin
          t1 = k;
          check("b2b_r0", result, 0);
          check("b2b_c0", cout, 0);
        end else if (t2 < 0) begin
          t2 = k;
          check("b2b_r1", result, 7);
          check("b2b_c1", cout, 0);
        end
      end
    end
    check("b2b_first", t1, W);
    check("b2b_spacing", t2 - t1, W + 2);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    check("b2b_drained", in_ready, 1);

`ifdef SERIAL_ALU_SUB_EN
    do_op(5, 3, 1, 1, 0);
    do_op(2, 3, 1, 1, 0);
`endif

    for (int i = 0; i < 25; i++) begin
      int s;
`ifdef SERIAL_ALU_SUB_EN
      s = int'($urandom_range(0, 1));
`else
      s = 0;
`endif
      do_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
            int'($urandom_range(0, 1)), s, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=stalled expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_alu_driver.md
Name: serial_alu_driver

Overview:
- Multi-cycle, bit-serial counterpart of the combinational 3-bit ALU adder.
- Accepts an operand pair plus carry-in over a valid/ready handshake.
- Computes a + b + cin one bit per clock, LSB first.
- Presents result and carry-out over a second valid/ready handshake.
- Serves as the sequential reference for equivalence checks against the combinational ALU in the simple test suite.

Parameters:
WIDTH, 3, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- One clock, clk. Reset is asynchronous and active-high, on port rst.
- Reset values: state=IDLE, out_valid=0, result=0, cout=0, busy=0.
- in_ready decodes combinationally from state IDLE, so in_ready=1 during and after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - on in_valid=1 at a clock edge: latch a into shift register SA, latch b into SB, set carry register C=cin, clear bit counter, clear result register, go to RUN.
  - in_valid=0: stay in IDLE; the operand inputs are don't-care.
- RUN:
  - in_ready=0; in_valid is ignored.
  - each edge computes s = SA[0]^SB[0]^C and C' = majority(SA[0], SB[0], C).
  - SA and SB shift right; s shifts into result at the MSB end; counter increments.
  - on the edge that processes bit WIDTH-1: go to DONE, set out_valid=1, cout=C'.
- DONE:
  - out_valid=1; result and cout hold stable until the transfer.
  - transfer occurs on an edge with out_ready=1; then go to IDLE and set out_valid=0.
  - result and cout hold their last values in IDLE; they are valid only while out_valid=1.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles when out_ready=1 and in_valid=1 are held continuously. There is no overlap of acceptance with DONE.
- Arithmetic: {cout, result} == a + b + cin, computed in WIDTH+1 bits. Wrap-around is expected, not an error.
- Counter width: clog2(WIDTH+1).
- WIDTH=1: RUN lasts exactly one cycle.
- Reset in RUN or DONE aborts the operation with no output: state returns to IDLE immediately (asynchronous) and all outputs take their reset values.
- out_ready=1 outside DONE has no effect.

Optional Feature:
SERIAL_ALU_SUB_EN
- Defined:
  - adds input port sub (1 bit), latched together with the operands.
  - sub=1 inverts b at latch time, so the computed value is a + ~b + cin.
  - with cin=1 this gives a - b, and cout=1 means no borrow.
  - sub=0 behaves identically to the undefined build.
- Undefined: no sub port; add only.

Test Plan (WIDTH=3):
- Basic add: a=3, b=2, cin=0, out_ready=1 → result=5, cout=0, out_valid high exactly 3 edges after acceptance, then IDLE and in_ready=1 on the following cycle.
- Overflow: a=7, b=1, cin=1 → result=1, cout=1; also a=7, b=7, cin=1 → result=7, cout=1.
- Backpressure:
  - setup: complete a=4, b=1 with out_ready=0 for 5 cycles, while in_valid=1 carries different operands.
  - DONE phase: out_valid stays 1, result=5 stable, in_ready=0, new operands not accepted.
  - after out_ready=1: the block accepts the waiting operands on the first IDLE cycle.
- Reset mid-operation: assert rst asynchronously (between edges) after 1 RUN edge → out_valid=0, result=0, cout=0, busy=0 before the next edge; no result emitted; next transaction a=1, b=1 gives result=2.
- Back-to-back: in_valid and out_ready held at 1 with 0+0+0 then 6+1+0 → results 0 and 7, cout=0 for both, spaced WIDTH+2=5 cycles apart.
- SERIAL_ALU_SUB_EN build: sub=1, cin=1 with a=5, b=3 → result=2, cout=1; with a=2, b=3 → result=7, cout=0.
